// File: rtl/jtag_master_seq_if.sv
// Host-side command/response bundle for jtag_master_seq.
// The master modport is the host and the slave modport is the sequencer.
interface jtag_master_seq_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
);
    logic              cmdValid;
    logic              cmdReady;
    logic [1:0]        cmdOp;
    logic [LEN_W-1:0]  cmdLen;
    logic [DATA_W-1:0] cmdData;
    logic              rspValid;
    logic              rspErr;
    logic [DATA_W-1:0] rspData;
    logic              busy;

    modport master (
        output cmdValid, cmdOp, cmdLen, cmdData,
        input  cmdReady, rspValid, rspErr, rspData, busy
    );

    modport slave (
        input  cmdValid, cmdOp, cmdLen, cmdData,
        output cmdReady, rspValid, rspErr, rspData, busy
    );
endinterface

// File: rtl/jtag_master_seq.sv
// Command-driven JTAG master: turns whole TAP-reset / IR / DR scan commands into TMS/TDI streams.
// Define JTAG_RTI_WAIT_EN to enable op 11 (hold TAP in Run-Test/Idle for CMD_LEN cycles).
module jtag_master_seq #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    jtag_master_seq_if.slave    bus,
    output logic                tms_o,
    output logic                tdi_o,
    input  logic                tdo_i
);
    localparam logic [2:0] S_TLR   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_UPD   = 3'd4;
`ifdef JTAG_RTI_WAIT_EN
    localparam logic [2:0] S_WAIT  = 3'd5;
`endif

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rspData_q, rspData_d;
    logic              isIr_q, isIr_d;
    logic              tlrRsp_q, tlrRsp_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              rspValid_q, rspValid_d;
    logic              rspErr_q, rspErr_d;

    logic accept;
    logic lenOk;
    logic hdrDone;
    logic lastBit;

    assign accept  = bus.cmdValid && (state_q == S_IDLE);
    assign lenOk   = (bus.cmdLen != '0) && (bus.cmdLen <= MAX_LEN);
    assign hdrDone = (cnt_q == (isIr_q ? LEN_W'(3) : LEN_W'(2)));
    assign lastBit = (cnt_q == (len_q - ONE));

    // cnt_q always indexes the TMS/TDI bit currently presented to the TAP
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        rspData_d  = rspData_q;
        isIr_d     = isIr_q;
        tlrRsp_d   = tlrRsp_q;
        tms_d      = 1'b0;
        tdi_d      = 1'b0;
        rspValid_d = 1'b0;
        rspErr_d   = 1'b0;

        case (state_q)
            S_TLR: begin
                cnt_d = cnt_q + ONE;
                tms_d = (cnt_q < LEN_W'(4));
                if (cnt_q == LEN_W'(5)) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    rspValid_d = tlrRsp_q;
                    tlrRsp_d   = 1'b0;
                end
            end

            S_IDLE: begin
                if (accept) begin
                    len_d     = bus.cmdLen;
                    data_d    = bus.cmdData;
                    isIr_d    = (bus.cmdOp == 2'b01);
                    rspData_d = '0;
                    cnt_d     = '0;
                    case (bus.cmdOp)
                        2'b00: begin
                            state_d  = S_TLR;
                            tms_d    = 1'b1;
                            tlrRsp_d = 1'b1;
                        end
                        2'b01, 2'b10: begin
                            if (lenOk) begin
                                state_d = S_HDR;
                                tms_d   = 1'b1;
                            end else begin
                                rspValid_d = 1'b1;
                                rspErr_d   = 1'b1;
                            end
                        end
                        default: begin
`ifdef JTAG_RTI_WAIT_EN
                            if (bus.cmdLen == '0) begin
                                rspValid_d = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                            end
`else
                            rspValid_d = 1'b1;
                            rspErr_d   = 1'b1;
`endif
                        end
                    endcase
                end
            end

            // Header TMS: DR 1,0,0 / IR 1,1,0,0; only IR bit 1 is a second one
            S_HDR: begin
                if (hdrDone) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    tms_d   = (len_q == ONE);
                    tdi_d   = data_q[0];
                    data_d  = data_q >> 1;
                end else begin
                    cnt_d = cnt_q + ONE;
                    tms_d = isIr_q && (cnt_q == '0);
                end
            end

            S_SHIFT: begin
                rspData_d = rspData_q | (DATA_W'(tdo_i) << cnt_q);
                if (lastBit) begin
                    state_d = S_UPD;
                    cnt_d   = '0;
                    tms_d   = 1'b1;
                end else begin
                    cnt_d  = cnt_q + ONE;
                    tms_d  = ((cnt_q + LEN_W'(2)) == len_q);
                    tdi_d  = data_q[0];
                    data_d = data_q >> 1;
                end
            end

            S_UPD: begin
                if (cnt_q == '0) begin
                    cnt_d = ONE;
                end else begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    rspValid_d = 1'b1;
                end
            end

`ifdef JTAG_RTI_WAIT_EN
            S_WAIT: begin
                cnt_d = cnt_q + ONE;
                if (lastBit) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    rspValid_d = 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_TLR;
                cnt_d   = '0;
                tms_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_TLR;
            cnt_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            rspData_q  <= '0;
            isIr_q     <= 1'b0;
            tlrRsp_q   <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
            rspData_q  <= rspData_d;
            isIr_q     <= isIr_d;
            tlrRsp_q   <= tlrRsp_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
        end
    end

    assign bus.cmdReady = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.rspValid = rspValid_q;
    assign bus.rspErr   = rspErr_q;
    assign bus.rspData  = rspData_q;
    assign tms_o        = tms_q;
    assign tdi_o        = tdi_q;
endmodule

// File: tb/tb_jtag_master_seq.sv
// Self-checking bench for jtag_master_seq: spec vector table, TRST corner cases and random commands.
// Follows JTAG_RTI_WAIT_EN the same way as the design build.
module tb_jtag_master_seq;
    logic clk;
    logic rst;
    logic tdo;
    logic tms;
    logic tdi;

    int checks   = 0;
    int failures = 0;

    bit expTms[$];
    int shiftLo;
    int shiftHi;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic [31:0] pat;
        int          expLat;
        bit          expErr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[11];

    jtag_master_seq_if #(.DATA_W(32), .LEN_W(6)) busIf ();

    jtag_master_seq #(.DATA_W(32), .LEN_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (busIf.slave),
        .tms_o (tms),
        .tdi_o (tdi),
        .tdo_i (tdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: TMS sequence per cycle after acceptance, shift window, latency and response
    task automatic buildModel(input logic [1:0] op, input logic [5:0] len, input logic [31:0] pat,
                              output int lat, output bit err, output logic [31:0] d);
        int hdr;
        logic [63:0] mask;
        expTms.delete();
        shiftLo = 0;
        shiftHi = -1;
        err = 1'b0;
        d = '0;
        if (op == 2'b00) begin
            expTms = '{1, 1, 1, 1, 1, 0};
            lat = 7;
        end else if ((op == 2'b01 || op == 2'b10) && len >= 1 && len <= 32) begin
            if (op == 2'b01) expTms = '{1, 1, 0, 0};
            else             expTms = '{1, 0, 0};
            hdr = expTms.size();
            shiftLo = hdr + 1;
            shiftHi = hdr + int'(len);
            for (int k = 0; k < int'(len); k++) expTms.push_back(k == int'(len) - 1);
            expTms.push_back(1'b1);
            expTms.push_back(1'b0);
            lat = hdr + int'(len) + 3;
            mask = (64'd1 << len) - 64'd1;
            d = pat & mask[31:0];
        end
`ifdef JTAG_RTI_WAIT_EN
        else if (op == 2'b11) begin
            for (int k = 0; k < int'(len); k++) expTms.push_back(1'b0);
            lat = int'(len) + 1;
        end
`endif
        else begin
            lat = 1;
            err = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge of the response cycle
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                                 input logic [31:0] pat, input int expLat, input bit expErr,
                                 input logic [31:0] expData, input string tag);
        int waitCnt = 0;
        int mLat;
        bit mErr;
        logic [31:0] mData;
        logic [31:0] tmp;
        bit tmsExp;
        while (!busIf.cmdReady && waitCnt < 60) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, " ready"}, 64'(busIf.cmdReady), 64'd1);
        if (!busIf.cmdReady) return;
        buildModel(op, len, pat, mLat, mErr, mData);
        busIf.cmdValid = 1'b1;
        busIf.cmdOp    = op;
        busIf.cmdLen   = len;
        busIf.cmdData  = data;
        @(posedge clk);
        for (int n = 1; n <= expLat; n++) begin
            #1;
            busIf.cmdValid = 1'b0;
            busIf.cmdOp    = 2'($urandom);
            busIf.cmdLen   = 6'($urandom);
            busIf.cmdData  = $urandom;
            if (n >= shiftLo && n <= shiftHi) begin
                tmp = pat >> (n - shiftLo);
                tdo = tmp[0];
            end else begin
                tdo = 1'($urandom);
            end
            @(negedge clk);
            tmsExp = (n <= expTms.size()) ? expTms[n-1] : 1'b0;
            checkOutput($sformatf("%s tms c%0d", tag, n), 64'(tms), 64'(tmsExp));
            if (n >= shiftLo && n <= shiftHi) begin
                tmp = data >> (n - shiftLo);
                checkOutput($sformatf("%s tdi c%0d", tag, n), 64'(tdi), 64'(tmp[0]));
            end
            checkOutput($sformatf("%s rspValid c%0d", tag, n), 64'(busIf.rspValid), 64'(n == expLat));
            if (n == expLat) begin
                checkOutput({tag, " rspErr"}, 64'(busIf.rspErr), 64'(expErr));
                checkOutput({tag, " rspData"}, 64'(busIf.rspData), 64'(expData));
                checkOutput({tag, " readyAtRsp"}, 64'(busIf.cmdReady), 64'd1);
                checkOutput({tag, " busyAtRsp"}, 64'(busIf.busy), 64'd0);
            end else begin
                checkOutput($sformatf("%s busy c%0d", tag, n), 64'(busIf.busy), 64'd1);
                @(posedge clk);
            end
        end
    endtask

    // Called at the negedge where reset has just been released
    task automatic checkTlrSeq(input string tag);
        checkOutput({tag, " tms c1"}, 64'(tms), 64'd1);
        checkOutput({tag, " ready c1"}, 64'(busIf.cmdReady), 64'd0);
        for (int n = 2; n <= 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("%s tms c%0d", tag, n), 64'(tms), 64'(n <= 5));
            checkOutput($sformatf("%s ready c%0d", tag, n), 64'(busIf.cmdReady), 64'd0);
            checkOutput($sformatf("%s rspValid c%0d", tag, n), 64'(busIf.rspValid), 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " ready c7"}, 64'(busIf.cmdReady), 64'd1);
        checkOutput({tag, " busy c7"}, 64'(busIf.busy), 64'd0);
        checkOutput({tag, " rspValid c7"}, 64'(busIf.rspValid), 64'd0);
        checkOutput({tag, " tms c7"}, 64'(tms), 64'd0);
    endtask

    initial begin
        int lat;
        bit err;
        logic [31:0] d;
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic [31:0] pat;

        vecs[0] = '{2'b10, 6'd8,  32'h0000_00A5, 32'h0000_003C, 14, 1'b0, 32'h0000_003C};
        vecs[1] = '{2'b01, 6'd4,  32'h0000_0002, 32'hFFFF_FFFF, 11, 1'b0, 32'h0000_000F};
        vecs[2] = '{2'b10, 6'd0,  32'h1234_5678, 32'hFFFF_FFFF, 1,  1'b1, 32'h0000_0000};
        vecs[3] = '{2'b01, 6'd33, 32'h1234_5678, 32'hFFFF_FFFF, 1,  1'b1, 32'h0000_0000};
        vecs[4] = '{2'b00, 6'd0,  32'h0000_0000, 32'hFFFF_FFFF, 7,  1'b0, 32'h0000_0000};
        vecs[5] = '{2'b10, 6'd1,  32'h0000_0001, 32'h0000_0001, 7,  1'b0, 32'h0000_0001};
        vecs[6] = '{2'b10, 6'd32, 32'hDEAD_BEEF, 32'h1234_5678, 38, 1'b0, 32'h1234_5678};
        vecs[7] = '{2'b01, 6'd32, 32'h0000_0000, 32'hFFFF_FFFF, 39, 1'b0, 32'hFFFF_FFFF};
        vecs[8] = '{2'b10, 6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  1'b1, 32'h0000_0000};
`ifdef JTAG_RTI_WAIT_EN
        vecs[9]  = '{2'b11, 6'd5, 32'h0, 32'h0, 6, 1'b0, 32'h0};
        vecs[10] = '{2'b11, 6'd0, 32'h0, 32'h0, 1, 1'b0, 32'h0};
`else
        vecs[9]  = '{2'b11, 6'd5, 32'h0, 32'h0, 1, 1'b1, 32'h0};
        vecs[10] = '{2'b11, 6'd0, 32'h0, 32'h0, 1, 1'b1, 32'h0};
`endif

        rst = 1'b1;
        tdo = 1'b0;
        busIf.cmdValid = 1'b0;
        busIf.cmdOp    = 2'b00;
        busIf.cmdLen   = '0;
        busIf.cmdData  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset tms", 64'(tms), 64'd1);
        checkOutput("reset tdi", 64'(tdi), 64'd0);
        checkOutput("reset ready", 64'(busIf.cmdReady), 64'd0);
        checkOutput("reset busy", 64'(busIf.busy), 64'd1);
        checkOutput("reset rspValid", 64'(busIf.rspValid), 64'd0);
        checkOutput("reset rspErr", 64'(busIf.rspErr), 64'd0);
        checkOutput("reset rspData", 64'(busIf.rspData), 64'd0);
        rst = 1'b0;
        checkTlrSeq("por");

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].pat,
                          vecs[i].expLat, vecs[i].expErr, vecs[i].expData, $sformatf("vec%0d", i));
        end

        // TRST during shift bit 3 of an 8-bit DR scan
        @(negedge clk);
        busIf.cmdValid = 1'b1;
        busIf.cmdOp    = 2'b10;
        busIf.cmdLen   = 6'd8;
        busIf.cmdData  = 32'h0000_00FF;
        @(posedge clk);
        #1;
        busIf.cmdValid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort tms bit3", 64'(tms), 64'd0);
        checkOutput("abort tdi bit3", 64'(tdi), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort tms", 64'(tms), 64'd1);
        checkOutput("abort ready", 64'(busIf.cmdReady), 64'd0);
        checkOutput("abort busy", 64'(busIf.busy), 64'd1);
        checkOutput("abort rspValid", 64'(busIf.rspValid), 64'd0);
        checkOutput("abort rspData", 64'(busIf.rspData), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkTlrSeq("post-trst");
        pat = 32'($urandom_range(0, 1));
        applyStimulus(2'b10, 6'd1, 32'h0, pat, 7, 1'b0, pat, "len1-after-trst");

        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            len  = 6'($urandom_range(0, 35));
            data = $urandom;
            pat  = $urandom;
            buildModel(op, len, pat, lat, err, d);
            applyStimulus(op, len, data, pat, lat, err, d, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtag_master_seq.md
Name: jtag_master_seq

Overview:
- Command-driven JTAG master that sequences a tap_ctl-style TAP: generates TMS/TDI bit streams for TAP reset, IR scan and DR scan, and collects TDO.
- Sits between a host/debug bus and the TAP pins; the TAP state is tracked internally so the host issues whole scans, not TMS bits.
- Single TCK domain; the TAP is at Run-Test/Idle (RTI) between commands.

Parameters:
- DATA_W, 32, maximum scan length in bits and width of CMD_DATA/RSP_DATA.
- LEN_W, 6, width of CMD_LEN; must satisfy 2^LEN_W > DATA_W.

Ports:
- TCK  in  1  clock; all state updates on posedge.
- TRST  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  block accepts a command this cycle; high only in S_IDLE.
- CMD_OP  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 RTI wait (optional feature).
- CMD_LEN  in  LEN_W  scan length in bits, or wait cycles for op 11.
- CMD_DATA  in  DATA_W  TDI bits, LSB shifted first.
- RSP_VALID  out  1  one-cycle pulse at command completion; no backpressure.
- RSP_ERR  out  1  qualifies RSP_VALID; command rejected.
- RSP_DATA  out  DATA_W  captured TDO, right-justified, upper bits zero.
- BUSY  out  1  high whenever not in S_IDLE.
- TMS  out  1  registered TMS to the TAP.
- TDI  out  1  registered TDI to the TAP.
- TDO  in  1  TAP serial output.

Behaviour:
Reset values:
- TMS=1, TDI=0, CMD_READY=0, BUSY=1, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0.
- State is S_TLR with its count cleared.

Handshake:
- A command is accepted at a posedge with CMD_VALID && CMD_READY.
- CMD_OP, CMD_LEN and CMD_DATA are latched on acceptance; later input changes are ignored.

States:
- S_TLR:
  - Drives TMS=1 for 5 cycles, then TMS=0 for 1 cycle, leaving the TAP in RTI.
  - Entered after TRST release, and also for op 00. Op 00 takes 6 cycles, then pulses RSP_VALID with RSP_DATA=0.
- S_IDLE: TMS=0, TDI=0 (TAP parked in RTI); CMD_READY=1.
- S_HDR:
  - DR header TMS sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR header TMS sequence 1,1,0,0.
- S_SHIFT:
  - One bit per cycle; TDI=data[k] for k=0..LEN-1.
  - TMS=0 for k<LEN-1 and TMS=1 on k=LEN-1, which moves the TAP to Exit1.
  - TDO is sampled at the same posedge that ends TDI bit k, into RSP_DATA[k].
- S_UPD: TMS=1 (to Update), then TMS=0 (to RTI). RSP_VALID pulses in the cycle after the TMS=0 cycle, and the state returns to S_IDLE in that same cycle.
- S_WAIT: optional feature; see below.

Latency (acceptance edge to RSP_VALID):
- DR scan: LEN+6 cycles.
- IR scan: LEN+7 cycles.
- Reset: 7 cycles.
- The next command can be accepted on the cycle RSP_VALID is high.

Boundary rules:
- CMD_LEN=0 or CMD_LEN>DATA_W on a scan op: no TAP activity (TMS stays 0); RSP_VALID+RSP_ERR=1 on the next cycle; RSP_DATA=0.
- LEN=1: the single shift bit carries TMS=1.
- LEN=DATA_W fills RSP_DATA completely.
- RSP_DATA is cleared on acceptance and holds its value until the next acceptance.
- TRST mid-command: immediate return to reset values. No response is issued for the aborted command, and the S_TLR sequence reruns after release.

Optional Feature:
- Macro: JTAG_RTI_WAIT_EN.
- Defined: op 11 enters S_WAIT and holds TMS=0 for CMD_LEN cycles (LEN=0 means zero cycles). RSP_VALID then pulses with RSP_ERR=0. Latency is CMD_LEN+1.
- Undefined: op 11 is rejected like an illegal length (RSP_ERR=1 next cycle, no TAP activity). S_WAIT and its counter are not synthesized.

Test Plan:
- TRST pulse then release -> TMS 1,1,1,1,1,0 over 6 cycles; CMD_READY rises on cycle 7; BUSY falls together with CMD_READY.
- DR scan, LEN=8, DATA=0xA5, TDO driven with pattern 0x3C LSB first -> TMS=1,0,0,0x7,1,1,0 and TDI=1,0,1,0,0,1,0,1 during shift; RSP_VALID at cycle 14 with RSP_DATA=0x3C, RSP_ERR=0.
- IR scan, LEN=4, DATA=0x2, TDO held 1 -> header TMS 1,1,0,0; RSP_VALID at cycle 11; RSP_DATA=0xF.
- Scan with LEN=0, then LEN=33 (DATA_W=32) -> RSP_ERR=1 one cycle after acceptance, TMS constant 0, RSP_DATA=0.
- TRST asserted at shift bit 3 of an 8-bit DR scan -> TMS=1 immediately, no RSP_VALID, reset sequence reruns after release; a following LEN=1 DR scan returns TDO in RSP_DATA[0].
- Op 11, LEN=5 -> with JTAG_RTI_WAIT_EN: TMS=0 for 5 cycles, RSP_VALID at cycle 6, RSP_ERR=0; without it: RSP_ERR=1 at cycle 1.
